// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: IEEE single layout, special encodings and the
// per-stage record that flows through the pipelined adder.
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int TAG_MAX = 16;
    localparam int SIG_W   = MAN_W + 4;
    localparam int EXPX_W  = EXP_W + 2;
    localparam int LZC_W   = $clog2(SIG_W + 1);

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam logic [31:0] NEG_INF   = 32'hFF800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    // Significands are {hidden, fraction, guard, round, sticky}; sticky lives in bit 0.
    typedef struct packed {
        logic                     valid;
        logic [TAG_MAX-1:0]       tag;
        logic                     sign;
        logic signed [EXPX_W-1:0] exp;
        logic [SIG_W-1:0]         mant;
        logic [SIG_W-1:0]         mant_b;
        logic                     eff_sub;
        logic                     zero_sign;
        logic                     inv;
        logic                     inf;
    } stage_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fadd_pipe.sv
// Stallable pipelined IEEE-754 single-precision adder/subtractor with tag passthrough.
// Phases: align, magnitude add, normalise, round/pack; NSTAGE picks the register cuts.
module fadd_pipe
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    output logic             unf,
    output logic             inv
);

    // Handshake: a transfer occurs on any edge with valid && ready on that side. A held
    // output (out_valid && !out_ready) freezes every stage, so in_ready is just !stall.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    stage_t r1, c1, r2, c2, r3, c3;

    fp32_t             op_a, op_b, op_hi, op_lo;
    logic              swap, nan_a, nan_b, inf_a, inf_b;
    logic [EXP_W-1:0]  shift;
    logic [SIG_W-1:0]  m_hi, m_lo, lost_mask;

    always_comb begin
        op_a      = x1;
        op_b      = x2;
        op_b.sign = x2[31] ^ sub;
        nan_a     = (op_a.exp == '1) && (op_a.man != '0);
        nan_b     = (op_b.exp == '1) && (op_b.man != '0);
        inf_a     = (op_a.exp == '1) && (op_a.man == '0);
        inf_b     = (op_b.exp == '1) && (op_b.man == '0);
        swap      = {op_b.exp, op_b.man} > {op_a.exp, op_a.man};
        op_hi     = swap ? op_b : op_a;
        op_lo     = swap ? op_a : op_b;
        // Denormal inputs carry no hidden bit and are treated as signed zero.
        m_hi      = (op_hi.exp == '0) ? '0 : {1'b1, op_hi.man, 3'b000};
        m_lo      = (op_lo.exp == '0) ? '0 : {1'b1, op_lo.man, 3'b000};
        shift     = op_hi.exp - op_lo.exp;
        lost_mask = ~({SIG_W{1'b1}} << shift);

        r1           = '0;
        r1.valid     = in_valid;
        r1.tag       = TAG_MAX'(in_tag);
        r1.sign      = op_hi.sign;
        r1.exp       = {2'b00, op_hi.exp};
        r1.mant      = m_hi;
        r1.mant_b    = (m_lo >> shift) | {{(SIG_W-1){1'b0}}, |(m_lo & lost_mask)};
        r1.eff_sub   = op_hi.sign ^ op_lo.sign;
        r1.zero_sign = op_a.sign & op_b.sign;
        r1.inv       = nan_a | nan_b | (inf_a & inf_b & (op_a.sign ^ op_b.sign));
        r1.inf       = inf_a | inf_b;
    end

    logic [SIG_W:0] sum;

    always_comb begin
        r2  = c1;
        sum = c1.eff_sub ? ({1'b0, c1.mant} - {1'b0, c1.mant_b})
                         : ({1'b0, c1.mant} + {1'b0, c1.mant_b});
        if (sum[SIG_W]) begin
            r2.mant = {sum[SIG_W:2], sum[1] | sum[0]};
            r2.exp  = c1.exp + EXPX_W'(1);
        end else begin
            r2.mant = sum[SIG_W-1:0];
        end
        r2.mant_b = '0;
    end

    logic [LZC_W-1:0] lz;

    fpu_lzc #(.W(SIG_W), .CW(LZC_W)) u_lzc (
        .value (c2.mant),
        .count (lz)
    );

    always_comb begin
        r3      = c2;
        r3.mant = c2.mant << lz;
        r3.exp  = c2.exp - EXPX_W'(lz);
    end

    logic [MAN_W:0]           rnd;
    logic                     round_up;
    logic signed [EXPX_W-1:0] exp_r;
    logic [31:0]              y_n;
    logic                     ovf_n, unf_n, inv_n;

    always_comb begin
        round_up = c3.mant[2] & (c3.mant[1] | c3.mant[0] | c3.mant[3]);
        rnd      = {1'b0, c3.mant[SIG_W-2:3]} + {{MAN_W{1'b0}}, round_up};
        exp_r    = c3.exp + EXPX_W'(rnd[MAN_W]);
        y_n      = {c3.sign, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        inv_n    = 1'b0;
        if (c3.inv) begin
            y_n   = CANON_NAN;
            inv_n = 1'b1;
        end else if (c3.inf) begin
            y_n = c3.sign ? NEG_INF : POS_INF;
        end else if (c3.mant == '0) begin
            y_n = {c3.zero_sign, 31'b0};
        end else if (exp_r >= EXPX_W'(255)) begin
            y_n   = c3.sign ? NEG_INF : POS_INF;
            ovf_n = 1'b1;
        end else if (exp_r < EXPX_W'(1)) begin
            y_n   = {c3.sign, 31'b0};
            unf_n = 1'b1;
        end
    end

    generate
        if (NSTAGE >= 3) begin : g_cut1
            always_ff @(posedge clk) begin
                if (rst)         c1 <= '0;
                else if (!stall) c1 <= r1;
            end
        end else begin : g_pass1
            assign c1 = r1;
        end

        if (NSTAGE >= 2) begin : g_cut2
            always_ff @(posedge clk) begin
                if (rst)         c2 <= '0;
                else if (!stall) c2 <= r2;
            end
        end else begin : g_pass2
            assign c2 = r2;
        end

        if (NSTAGE >= 4) begin : g_cut3
            always_ff @(posedge clk) begin
                if (rst)         c3 <= '0;
                else if (!stall) c3 <= r3;
            end
        end else begin : g_pass3
            assign c3 = r3;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
        end else if (!stall) begin
            out_valid <= c3.valid;
            y         <= y_n;
            out_tag   <= c3.tag[TAG_W-1:0];
            ovf       <= ovf_n;
            unf       <= unf_n;
            inv       <= inv_n;
        end
    end

endmodule
